// File: rtl/tls_sess_sched.sv
// Session scheduler for the TLS classifier: round-robin grants one requester per
// 4-packet session, streams fixed 32-beat windows and reports the verdict or a stall abort.
//
// state       | meaning
// S_IDLE      | arbitrate among i_req, rr pointer picks first set bit after last winner
// S_WAIT_PKT  | session granted, waiting for i_req_vld of the granted requester
// S_STREAM    | 32-cycle packet window, beats then zero padding
// S_CAPTURE   | sample classifier verdict after beat 32 of packet 4
// S_FLUSH     | requester stalled: drive pkt 4 / cycle 32 to clear the classifier
// S_FLUSH_RPT | report the aborted session
module tls_sess_sched #(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 11
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [N_REQ-1:0]     i_req,
   input  logic [N_REQ-1:0]     i_req_vld,
   input  logic [64*N_REQ-1:0]  i_req_data,
   input  logic [8*N_REQ-1:0]   i_req_len,
   input  logic [8*N_REQ-1:0]   i_req_proto,
   input  logic [8*N_REQ-1:0]   i_req_flow_id,
   output logic [N_REQ-1:0]     o_gnt,
   output logic [N_REQ-1:0]     o_rd_en,
   output logic                 o_pkt_data_valid,
   output logic [63:0]          o_pkt_data,
   output logic [7:0]           o_pkt_len,
   output logic [2:0]           o_pkt_num,
   output logic [7:0]           o_pkt_protocol,
   output logic [5:0]           o_pkt_cycle_cnt,
   output logic [7:0]           o_flow_id,
   input  logic [2:0]           i_flow_type,
   output logic                 o_res_valid,
   output logic [2:0]           o_res_type,
   output logic [7:0]           o_res_flow_id,
   output logic [2:0]           o_res_req,
   output logic                 o_res_timeout
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_PKT, S_STREAM, S_CAPTURE, S_FLUSH, S_FLUSH_RPT
   } state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [2:0]         gidx_q, gidx_d;
   logic [2:0]         rr_q, rr_d;
   logic [2:0]         pkt_num_q, pkt_num_d;
   logic [5:0]         cycle_q, cycle_d;
   logic [5:0]         beats_q, beats_d;
   logic [CNT_W-1:0]   to_q, to_d;
   logic [7:0]         len_q, len_d;
   logic [7:0]         proto_q, proto_d;
   logic [7:0]         flow_q, flow_d;
   logic               streamed_q, streamed_d;
   logic               res_valid_q, res_valid_d;
   logic [2:0]         res_type_q, res_type_d;
   logic [7:0]         res_flow_q, res_flow_d;
   logic [2:0]         res_req_q, res_req_d;
   logic               res_to_q, res_to_d;

   logic               sel_vld;
   logic [63:0]        sel_data;
   logic [7:0]         sel_len, sel_proto, sel_flow;
   logic               win_found;
   logic [2:0]         win_idx;
   logic [8:0]         len_up;

   always_comb begin
      sel_vld   = 1'b0;
      sel_data  = '0;
      sel_len   = '0;
      sel_proto = '0;
      sel_flow  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gidx_q == 3'(i)) begin
            sel_vld   = i_req_vld[i];
            sel_data  = i_req_data[i*64 +: 64];
            sel_len   = i_req_len[i*8 +: 8];
            sel_proto = i_req_proto[i*8 +: 8];
            sel_flow  = i_req_flow_id[i*8 +: 8];
         end
      end
   end

   // Two passes give "first set bit after rr_q" with wrap-around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (!win_found && i_req[j] && (3'(j) > rr_q)) begin
            win_found = 1'b1;
            win_idx   = 3'(j);
         end
      end
      for (int j = 0; j < N_REQ; j++) begin
         if (!win_found && i_req[j] && (3'(j) <= rr_q)) begin
            win_found = 1'b1;
            win_idx   = 3'(j);
         end
      end
   end

   assign len_up = {1'b0, sel_len} + 9'd7;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gidx_d      = gidx_q;
      rr_d        = rr_q;
      pkt_num_d   = pkt_num_q;
      cycle_d     = cycle_q;
      beats_d     = beats_q;
      to_d        = to_q;
      len_d       = len_q;
      proto_d     = proto_q;
      flow_d      = flow_q;
      streamed_d  = streamed_q;
      res_valid_d = 1'b0;
      res_type_d  = res_type_q;
      res_flow_d  = res_flow_q;
      res_req_d   = res_req_q;
      res_to_d    = res_to_q;

      o_rd_en          = '0;
      o_pkt_data_valid = 1'b0;
      o_pkt_data       = '0;
      o_pkt_len        = '0;
      o_pkt_num        = '0;
      o_pkt_protocol   = '0;
      o_pkt_cycle_cnt  = '0;
      o_flow_id        = '0;

      unique case (state_q)
         S_IDLE: begin
            if (win_found) begin
               gnt_d      = N_REQ'(1) << win_idx;
               gidx_d     = win_idx;
               rr_d       = win_idx;
               pkt_num_d  = 3'd1;
               to_d       = '0;
               streamed_d = 1'b0;
               state_d    = S_WAIT_PKT;
            end
         end
         S_WAIT_PKT: begin
            if (sel_vld) begin
               len_d      = sel_len;
               proto_d    = sel_proto;
               flow_d     = sel_flow;
               beats_d    = 6'(len_up >> 3);
               cycle_d    = 6'd1;
               streamed_d = 1'b1;
               state_d    = S_STREAM;
            end else if (to_q == CNT_W'(TIMEOUT_CYC-1)) begin
               state_d = S_FLUSH;
            end else begin
               to_d = to_q + CNT_W'(1);
            end
         end
         S_STREAM: begin
            o_pkt_cycle_cnt = cycle_q;
            o_pkt_num       = pkt_num_q;
            o_pkt_len       = len_q;
            o_pkt_protocol  = proto_q;
            o_flow_id       = flow_q;
            if (cycle_q <= beats_q) begin
               o_pkt_data_valid = 1'b1;
               o_pkt_data       = sel_data;
               o_rd_en          = gnt_q;
            end
            if (cycle_q == 6'd32) begin
               cycle_d = '0;
               if (pkt_num_q == 3'd4) begin
                  state_d = S_CAPTURE;
               end else begin
                  pkt_num_d = pkt_num_q + 3'd1;
                  to_d      = '0;
                  state_d   = S_WAIT_PKT;
               end
            end else begin
               cycle_d = cycle_q + 6'd1;
            end
         end
         S_CAPTURE: begin
            // The classifier clears on this same edge, so the verdict must be taken now.
            res_valid_d = 1'b1;
            res_type_d  = i_flow_type;
            res_flow_d  = flow_q;
            res_req_d   = gidx_q;
            res_to_d    = 1'b0;
            gnt_d       = '0;
            pkt_num_d   = '0;
            state_d     = S_IDLE;
         end
         S_FLUSH: begin
            o_pkt_num       = 3'd4;
            o_pkt_cycle_cnt = 6'd32;
            res_valid_d     = 1'b1;
            res_type_d      = '0;
            res_flow_d      = streamed_q ? flow_q : sel_flow;
            res_req_d       = gidx_q;
            res_to_d        = 1'b1;
            state_d         = S_FLUSH_RPT;
         end
         S_FLUSH_RPT: begin
            gnt_d     = '0;
            pkt_num_d = '0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         gnt_q       <= '0;
         gidx_q      <= '0;
         rr_q        <= 3'(N_REQ-1);
         pkt_num_q   <= '0;
         cycle_q     <= '0;
         beats_q     <= '0;
         to_q        <= '0;
         len_q       <= '0;
         proto_q     <= '0;
         flow_q      <= '0;
         streamed_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_type_q  <= '0;
         res_flow_q  <= '0;
         res_req_q   <= '0;
         res_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gidx_q      <= gidx_d;
         rr_q        <= rr_d;
         pkt_num_q   <= pkt_num_d;
         cycle_q     <= cycle_d;
         beats_q     <= beats_d;
         to_q        <= to_d;
         len_q       <= len_d;
         proto_q     <= proto_d;
         flow_q      <= flow_d;
         streamed_q  <= streamed_d;
         res_valid_q <= res_valid_d;
         res_type_q  <= res_type_d;
         res_flow_q  <= res_flow_d;
         res_req_q   <= res_req_d;
         res_to_q    <= res_to_d;
      end
   end

   assign o_gnt         = gnt_q;
   assign o_res_valid   = res_valid_q;
   assign o_res_type    = res_type_q;
   assign o_res_flow_id = res_flow_q;
   assign o_res_req     = res_req_q;
   assign o_res_timeout = res_to_q;

endmodule

// File: tb/tb_tls_sess_sched.sv
// Directed bench for tls_sess_sched: requester models feed packets, a monitor
// summarises every window and result pulse, the main sequence checks sessions.
module tb_tls_sess_sched;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    i_req, i_req_vld;
   logic [64*N-1:0] i_req_data;
   logic [8*N-1:0]  i_req_len, i_req_proto, i_req_flow_id;
   logic [N-1:0]    o_gnt, o_rd_en;
   logic            o_pkt_data_valid;
   logic [63:0]     o_pkt_data;
   logic [7:0]      o_pkt_len, o_pkt_protocol, o_flow_id;
   logic [2:0]      o_pkt_num;
   logic [5:0]      o_pkt_cycle_cnt;
   logic [2:0]      i_flow_type = 3'b111;
   logic            o_res_valid, o_res_timeout;
   logic [2:0]      o_res_type, o_res_req;
   logic [7:0]      o_res_flow_id;

   tls_sess_sched #(.N_REQ(N), .TIMEOUT_CYC(1024), .CNT_W(11)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_req_vld(i_req_vld),
      .i_req_data(i_req_data), .i_req_len(i_req_len), .i_req_proto(i_req_proto),
      .i_req_flow_id(i_req_flow_id), .o_gnt(o_gnt), .o_rd_en(o_rd_en),
      .o_pkt_data_valid(o_pkt_data_valid), .o_pkt_data(o_pkt_data), .o_pkt_len(o_pkt_len),
      .o_pkt_num(o_pkt_num), .o_pkt_protocol(o_pkt_protocol),
      .o_pkt_cycle_cnt(o_pkt_cycle_cnt), .o_flow_id(o_flow_id), .i_flow_type(i_flow_type),
      .o_res_valid(o_res_valid), .o_res_type(o_res_type), .o_res_flow_id(o_res_flow_id),
      .o_res_req(o_res_req), .o_res_timeout(o_res_timeout)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // requester models
   logic [7:0]   lens   [N][4];
   logic [7:0]   fids   [N][4];
   logic [7:0]   protos [N];
   int           npk    [N];
   int           pidx   [N];
   int           bptr   [N];
   logic [N-1:0] req_r = '0;
   logic [2:0]   verdict = 3'b000;

   function automatic logic [63:0] mkword(input int r, input int p, input int b);
      return {8'hA0 + 8'(r), 8'(p), 8'(b), 40'h5A5A5A5A5A};
   endfunction

   function automatic int gidx(input logic [N-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   always_comb begin
      i_req         = req_r;
      i_req_vld     = '0;
      i_req_data    = '0;
      i_req_len     = '0;
      i_req_proto   = '0;
      i_req_flow_id = '0;
      for (int i = 0; i < N; i++) begin
         i_req_vld[i]          = (npk[i] > 0);
         i_req_data[i*64 +: 64] = mkword(i, pidx[i], bptr[i]);
         i_req_proto[i*8 +: 8]  = protos[i];
         if (pidx[i] < 4) begin
            i_req_len[i*8 +: 8]     = lens[i][pidx[i]];
            i_req_flow_id[i*8 +: 8] = fids[i][pidx[i]];
         end
      end
   end

   // monitor state
   int         wq_num[$], wq_valid[$];
   logic [2:0] rq_type[$], rq_req[$];
   logic [7:0] rq_flow[$];
   logic       rq_to[$];
   int err_cnt = 0, n_flush = 0, flush_bad = 0;
   int cyc = 0, wend_cyc = 0, flush_cyc = 0, prev_cnt = 0, win_valid_cur = 0;

   always @(negedge clk) begin
      logic [N-1:0] pop, gs;
      logic         wend, last;
      int           g, p;
      cyc++;
      if (rst) begin
         prev_cnt = 0;
      end else begin
         pop = o_rd_en; gs = o_gnt; wend = 1'b0; last = 1'b0;
         g = gidx(o_gnt);
         p = (pidx[g] < 4) ? pidx[g] : 3;
         if ($countones(o_gnt) > 1) err_cnt++;
         if ((o_rd_en & ~o_gnt) != '0) err_cnt++;
         if (o_pkt_cycle_cnt != 0) begin
            if (o_pkt_cycle_cnt == 6'd32 && prev_cnt != 31) begin
               n_flush++;
               flush_cyc = cyc;
               if (o_pkt_num != 3'd4 || o_pkt_data_valid || o_pkt_data != '0 || o_rd_en != '0)
                  flush_bad++;
            end else begin
               if (int'(o_pkt_cycle_cnt) != prev_cnt + 1) err_cnt++;
               if (o_pkt_cycle_cnt == 6'd1) win_valid_cur = 0;
               if (o_pkt_len != lens[g][p] || o_pkt_protocol != protos[g] || o_flow_id != fids[g][p])
                  err_cnt++;
               if (o_pkt_data_valid) begin
                  win_valid_cur++;
                  if (o_pkt_data != mkword(g, pidx[g], bptr[g]) || o_rd_en != o_gnt) err_cnt++;
               end else if (o_pkt_data != '0 || o_rd_en != '0) begin
                  err_cnt++;
               end
               if (o_pkt_cycle_cnt == 6'd32) begin
                  wend = 1'b1;
                  last = (o_pkt_num == 3'd4);
                  wq_num.push_back(int'(o_pkt_num));
                  wq_valid.push_back(win_valid_cur);
                  wend_cyc = cyc;
               end
            end
         end
         if (o_res_valid) begin
            rq_type.push_back(o_res_type);
            rq_req.push_back(o_res_req);
            rq_flow.push_back(o_res_flow_id);
            rq_to.push_back(o_res_timeout);
         end
         prev_cnt = int'(o_pkt_cycle_cnt);
         @(posedge clk);
         #1;
         if (!rst) begin
            for (int i = 0; i < N; i++) begin
               if (pop[i]) bptr[i]++;
               if (gs[i]) req_r[i] = 1'b0;
            end
            if (wend) begin
               pidx[g]++;
               npk[g]--;
               bptr[g] = 0;
            end
            // verdict is only meaningful during the cycle after beat 32 of packet 4
            i_flow_type = last ? verdict : 3'b111;
         end
      end
   end

   task automatic reset_model();
      for (int i = 0; i < N; i++) begin
         npk[i] = 0; pidx[i] = 0; bptr[i] = 0; protos[i] = '0;
         for (int k = 0; k < 4; k++) begin lens[i][k] = '0; fids[i][k] = '0; end
      end
      req_r = '0;
      wq_num.delete(); wq_valid.delete();
      rq_type.delete(); rq_req.delete(); rq_flow.delete(); rq_to.delete();
      err_cnt = 0; n_flush = 0; flush_bad = 0;
   endtask

   task automatic load(input int r, input logic [7:0] l0, input logic [7:0] l1,
                       input logic [7:0] l2, input logic [7:0] l3,
                       input logic [7:0] fbase, input logic [7:0] pr, input int n);
      lens[r][0] = l0; lens[r][1] = l1; lens[r][2] = l2; lens[r][3] = l3;
      for (int k = 0; k < 4; k++) fids[r][k] = fbase + 8'(k);
      protos[r] = pr; npk[r] = n; pidx[r] = 0; bptr[r] = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      reset_model();
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_res(input string tag, input int n, input int budget);
      for (int k = 0; k < budget && rq_type.size() < n; k++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk({tag, "_res_cnt"}, rq_type.size(), n);
      chk({tag, "_proto_err"}, err_cnt, 0);
   endtask

   task automatic chk_win(input string tag, input int w, input int num, input int nv);
      chk({tag, "_win_num"}, (w < wq_num.size()) ? wq_num[w] : -1, num);
      chk({tag, "_win_valid"}, (w < wq_valid.size()) ? wq_valid[w] : -1, nv);
   endtask

   task automatic chk_res(input string tag, input int k, input logic [2:0] ty,
                          input logic [2:0] rq, input logic [7:0] fl, input logic to);
      if (k < rq_type.size()) begin
         chk({tag, "_res_type"}, rq_type[k], ty);
         chk({tag, "_res_req"}, rq_req[k], rq);
         chk({tag, "_res_flow"}, rq_flow[k], fl);
         chk({tag, "_res_to"}, rq_to[k], to);
      end else begin
         chk({tag, "_res_missing"}, k, rq_type.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_model();
      repeat (2) @(negedge clk);
      chk("rst_data", o_pkt_data, 64'h0);
      chk("rst_ctl", {o_gnt, o_rd_en, o_pkt_data_valid, o_pkt_len, o_pkt_num, o_pkt_protocol,
                      o_pkt_cycle_cnt, o_flow_id, o_res_valid, o_res_type, o_res_flow_id,
                      o_res_req, o_res_timeout}, 58'h0);
      rst = 1'b0;
      @(negedge clk);

      // 1: req0, 4 x len 64 -> 8 valid beats per window
      verdict = 3'b001;
      load(0, 8'd64, 8'd64, 8'd64, 8'd64, 8'h10, 8'h06, 4);
      req_r[0] = 1'b1;
      @(negedge clk);
      chk("t1_gnt_latency", o_gnt, 4'b0001);
      wait_res("t1", 1, 400);
      chk("t1_nwin", wq_num.size(), 4);
      for (int w = 0; w < 4; w++) chk_win("t1", w, w + 1, 8);
      chk_res("t1", 0, 3'b001, 3'd0, 8'h13, 1'b0);

      // 2: mixed lengths, proto 0x11, different verdict
      reset_model();
      verdict = 3'b010;
      load(0, 8'd100, 8'd40, 8'd8, 8'd1, 8'h20, 8'h11, 4);
      req_r[0] = 1'b1;
      wait_res("t2", 1, 400);
      chk_win("t2", 0, 1, 13);
      chk_win("t2", 1, 2, 5);
      chk_win("t2", 2, 3, 1);
      chk_win("t2", 3, 4, 1);
      chk_res("t2", 0, 3'b010, 3'd0, 8'h23, 1'b0);

      // 3: req1 and req3 together after reset -> req1 first, then req3
      do_reset();
      verdict = 3'b011;
      load(1, 8'd16, 8'd16, 8'd16, 8'd16, 8'h30, 8'h06, 4);
      load(3, 8'd24, 8'd24, 8'd24, 8'd24, 8'h40, 8'h11, 4);
      req_r = 4'b1010;
      wait_res("t3", 2, 800);
      chk("t3_nwin", wq_num.size(), 8);
      chk_win("t3", 0, 1, 2);
      chk_win("t3", 3, 4, 2);
      chk_win("t3", 4, 1, 3);
      chk_win("t3", 7, 4, 3);
      chk_res("t3a", 0, 3'b011, 3'd1, 8'h33, 1'b0);
      chk_res("t3b", 1, 3'b011, 3'd3, 8'h43, 1'b0);

      // 4: req2 supplies 2 packets then stalls -> flush and timeout report
      reset_model();
      verdict = 3'b101;
      load(2, 8'd32, 8'd32, 8'd48, 8'd48, 8'h50, 8'h06, 2);
      req_r[2] = 1'b1;
      wait_res("t4", 1, 2000);
      chk("t4_nwin", wq_num.size(), 2);
      chk_win("t4", 1, 2, 4);
      chk("t4_nflush", n_flush, 1);
      chk("t4_flush_drive", flush_bad, 0);
      chk("t4_flush_gap", flush_cyc - wend_cyc, 1025);
      chk_res("t4", 0, 3'b000, 3'd2, 8'h51, 1'b1);

      // 5: len 255 fills the window, len 0 is all padding
      reset_model();
      verdict = 3'b100;
      load(1, 8'd255, 8'd0, 8'd255, 8'd0, 8'h60, 8'h06, 4);
      req_r[1] = 1'b1;
      wait_res("t5", 1, 400);
      chk_win("t5", 0, 1, 32);
      chk_win("t5", 1, 2, 0);
      chk_win("t5", 2, 3, 32);
      chk_win("t5", 3, 4, 0);
      chk_res("t5", 0, 3'b100, 3'd1, 8'h63, 1'b0);

      // 6: reset mid-window of packet 3, then req0 regains first priority
      reset_model();
      verdict = 3'b110;
      load(0, 8'd64, 8'd64, 8'd64, 8'd64, 8'h70, 8'h06, 4);
      req_r[0] = 1'b1;
      for (int k = 0; k < 300 && !(o_pkt_num == 3'd3 && o_pkt_cycle_cnt == 6'd10); k++)
         @(negedge clk);
      chk("t6_reach_pkt3", o_pkt_num, 3'd3);
      rst = 1'b1;
      #1;
      chk("t6_rst_data", o_pkt_data, 64'h0);
      chk("t6_rst_ctl", {o_gnt, o_rd_en, o_pkt_data_valid, o_pkt_len, o_pkt_num, o_pkt_protocol,
                         o_pkt_cycle_cnt, o_flow_id, o_res_valid, o_res_type, o_res_flow_id,
                         o_res_req, o_res_timeout}, 58'h0);
      chk("t6_no_res", rq_type.size(), 0);
      do_reset();
      load(0, 8'd8, 8'd8, 8'd8, 8'd8, 8'h80, 8'h06, 4);
      load(1, 8'd8, 8'd8, 8'd8, 8'd8, 8'h90, 8'h06, 4);
      req_r = 4'b0011;
      wait_res("t6", 2, 800);
      chk_win("t6", 0, 1, 1);
      chk_res("t6a", 0, 3'b110, 3'd0, 8'h83, 1'b0);
      chk_res("t6b", 1, 3'b110, 3'd1, 8'h93, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
